// File: rtl/mprj_wb_bridge_pkg.sv
// mprj_wb_bridge_pkg: shared types and constants for the mprj Wishbone bridge.
//   state_t     - bridge FSM states (IDLE, REQ, RESP)
//   WB_ERR_DATA - read data returned to the master on a timed-out access
package mprj_wb_bridge_pkg;
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [31:0] WB_ERR_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/mprj_wb_timer.sv
// mprj_wb_timer: clear/enable/expire cycle counter for the bridge timeout.
//   core_clk, core_rstn - clock, synchronous active-low reset
//   clr_i               - force the count to zero (dominates en_i)
//   en_i                - count one cycle
//   expire_o            - high while enabled on the TIMEOUT_CYCLES-th counted cycle
module mprj_wb_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic core_clk,
    input  logic core_rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign cnt_d    = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    assign expire_o = en_i & (cnt_q == LAST);

    always_ff @(posedge core_clk) begin
        if (!core_rstn) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mprj_wb_bridge.sv
// mprj_wb_bridge: registered Wishbone bridge from the management core mprj_* bus to the user area.
//   core_clk, core_rstn        - clock, synchronous active-low reset
//   m_wb_iena                  - user return enable (low masks u_ack_i / u_dat_i)
//   m_cyc_i..m_dat_i           - master request; m_ack_o/m_dat_o master response
//   u_cyc_o..u_dat_o           - registered request to user area; u_ack_i/u_dat_i response
//   to_clr, timeout_flag,
//   timeout_adr                - sticky timeout status and last timed-out address
// Optional timeout logic is built only when MPRJ_WB_TIMEOUT_EN is defined; otherwise
// REQ waits for ack or abort and the timeout outputs are tied to zero.
module mprj_wb_bridge
    import mprj_wb_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        m_wb_iena,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    input  logic [3:0]  m_sel_i,
    input  logic [31:0] m_adr_i,
    input  logic [31:0] m_dat_i,
    output logic        m_ack_o,
    output logic [31:0] m_dat_o,
    output logic        u_cyc_o,
    output logic        u_stb_o,
    output logic        u_we_o,
    output logic [3:0]  u_sel_o,
    output logic [31:0] u_adr_o,
    output logic [31:0] u_dat_o,
    input  logic        u_ack_i,
    input  logic [31:0] u_dat_i,
    input  logic        to_clr,
    output logic        timeout_flag,
    output logic [31:0] timeout_adr
);
    state_t      state_q, state_d;
    logic        u_we_q;
    logic [3:0]  u_sel_q;
    logic [31:0] u_adr_q, u_dat_q, m_dat_q, m_dat_d;
    logic        cap, ack, expire, to_hit;

    assign ack     = u_ack_i & m_wb_iena;
    assign m_ack_o = (state_q == RESP);
    assign u_cyc_o = (state_q == REQ);
    assign u_stb_o = (state_q == REQ);
    assign u_we_o  = u_we_q;
    assign u_sel_o = u_sel_q;
    assign u_adr_o = u_adr_q;
    assign u_dat_o = u_dat_q;
    assign m_dat_o = m_dat_q;

    always_comb begin
        state_d = state_q;
        m_dat_d = m_dat_q;
        cap     = 1'b0;
        to_hit  = 1'b0;
        case (state_q)
            IDLE: if (m_cyc_i & m_stb_i) begin
                cap     = 1'b1;
                state_d = REQ;
            end
            REQ: if (ack) begin
                m_dat_d = u_we_q ? '0 : u_dat_i;
                state_d = RESP;
            end else if (!m_cyc_i) begin
                state_d = IDLE;
            end else if (expire) begin
                m_dat_d = WB_ERR_DATA;
                to_hit  = 1'b1;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            state_q <= IDLE;
            u_we_q  <= 1'b0;
            u_sel_q <= '0;
            u_adr_q <= '0;
            u_dat_q <= '0;
            m_dat_q <= '0;
        end else begin
            state_q <= state_d;
            m_dat_q <= m_dat_d;
            if (cap) begin
                u_we_q  <= m_we_i;
                u_sel_q <= m_sel_i;
                u_adr_q <= m_adr_i;
                u_dat_q <= m_dat_i;
            end
        end
    end

`ifdef MPRJ_WB_TIMEOUT_EN
    logic        flag_q, flag_d;
    logic [31:0] to_adr_q, to_adr_d;

    // Counter restarts every time REQ is entered because it is held clear elsewhere.
    mprj_wb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .core_clk (core_clk),
        .core_rstn(core_rstn),
        .clr_i    (state_q != REQ),
        .en_i     (state_q == REQ),
        .expire_o (expire)
    );

    // A new timeout beats a coincident clear.
    assign flag_d       = to_hit | (flag_q & ~to_clr);
    assign to_adr_d     = to_hit ? u_adr_q : to_adr_q;
    assign timeout_flag = flag_q;
    assign timeout_adr  = to_adr_q;

    always_ff @(posedge core_clk) begin
        if (!core_rstn) begin
            flag_q   <= 1'b0;
            to_adr_q <= '0;
        end else begin
            flag_q   <= flag_d;
            to_adr_q <= to_adr_d;
        end
    end
`else
    logic unused_to;

    assign expire       = 1'b0;
    assign timeout_flag = 1'b0;
    assign timeout_adr  = '0;
    assign unused_to    = to_clr ^ to_hit ^ TIMEOUT_CYCLES[0];
`endif
endmodule

// File: tb/tb_mprj_wb_bridge.sv
// tb_mprj_wb_bridge: scoreboard bench for mprj_wb_bridge (expected read data queued per transfer).
module tb_mprj_wb_bridge;
    localparam int unsigned TO = 16;

    logic        core_clk = 1'b0;
    logic        core_rstn, m_wb_iena, m_cyc_i, m_stb_i, m_we_i;
    logic [3:0]  m_sel_i;
    logic [31:0] m_adr_i, m_dat_i;
    logic        m_ack_o;
    logic [31:0] m_dat_o;
    logic        u_cyc_o, u_stb_o, u_we_o;
    logic [3:0]  u_sel_o;
    logic [31:0] u_adr_o, u_dat_o;
    logic        u_ack_i;
    logic [31:0] u_dat_i;
    logic        to_clr, timeout_flag;
    logic [31:0] timeout_adr;

    int total = 0;
    int bad = 0;
    int ack_cnt = 0;
    logic [31:0] exp_q[$];

    mprj_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .core_clk(core_clk), .core_rstn(core_rstn), .m_wb_iena(m_wb_iena),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .u_cyc_o(u_cyc_o), .u_stb_o(u_stb_o), .u_we_o(u_we_o), .u_sel_o(u_sel_o),
        .u_adr_o(u_adr_o), .u_dat_o(u_dat_o), .u_ack_i(u_ack_i), .u_dat_i(u_dat_i),
        .to_clr(to_clr), .timeout_flag(timeout_flag), .timeout_adr(timeout_adr)
    );

    always #5 core_clk = ~core_clk;

    // Scoreboard: every m_ack_o pops one expected read-data word.
    always @(posedge core_clk) begin
        #1;
        if (m_ack_o === 1'b1) begin
            ack_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack m_dat_o=%h expected no ack", m_dat_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (m_dat_o !== e) begin
                    bad++;
                    $display("FAIL ack_data got=%h want=%h", m_dat_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #2;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_dat_i = dat; m_sel_i = sel;
    endtask

    task automatic drop_req();
        m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    endtask

    // Wait up to limit edges for m_ack_o; returns edges waited (limit+1 if none).
    task automatic wait_ack(input int limit, output int n);
        n = 0;
        while (n <= limit && m_ack_o !== 1'b1) begin
            tick();
            n++;
        end
        if (m_ack_o !== 1'b1) n = limit + 1;
    endtask

    task automatic test_reset();
        core_rstn = 1'b0; m_wb_iena = 1'b1; drop_req(); m_sel_i = '0; m_adr_i = '0; m_dat_i = '0;
        u_ack_i = 1'b0; u_dat_i = '0; to_clr = 1'b0;
        repeat (3) tick();
        total++;
        if ({m_ack_o, m_dat_o, u_cyc_o, u_stb_o, u_we_o, u_sel_o, u_adr_o, u_dat_o, timeout_flag, timeout_adr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs ack=%b dat=%h cyc=%b adr=%h flag=%b tadr=%h want all 0",
                     m_ack_o, m_dat_o, u_cyc_o, u_adr_o, timeout_flag, timeout_adr);
        end
        core_rstn = 1'b1;
        u_ack_i = 1'b1; u_dat_i = 32'h1234_5678;
        repeat (3) tick();
        u_ack_i = 1'b0;
        total++;
        if (ack_cnt !== 0 || u_cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_ack_ignored acks=%0d cyc=%b want 0 0", ack_cnt, u_cyc_o);
        end
    endtask

    task automatic test_read();
        int a0;
        a0 = ack_cnt;
        drive_req(1'b0, 32'h3000_0004, 32'h0, 4'hF);
        exp_q.push_back(32'hA5A5_1234);
        tick();
        total++;
        if (u_stb_o !== 1'b1 || u_cyc_o !== 1'b1 || u_adr_o !== 32'h3000_0004 || u_we_o !== 1'b0) begin
            bad++;
            $display("FAIL read_req stb=%b cyc=%b adr=%h we=%b want 1 1 30000004 0", u_stb_o, u_cyc_o, u_adr_o, u_we_o);
        end
        u_ack_i = 1'b1; u_dat_i = 32'hA5A5_1234;
        tick();
        u_ack_i = 1'b0; drop_req();
        total++;
        if (m_ack_o !== 1'b1 || u_stb_o !== 1'b0) begin
            bad++;
            $display("FAIL read_ack_timing ack=%b stb=%b want 1 0", m_ack_o, u_stb_o);
        end
        repeat (2) tick();
        total++;
        if (ack_cnt - a0 !== 1 || m_dat_o !== 32'hA5A5_1234) begin
            bad++;
            $display("FAIL read_single_ack acks=%0d dat=%h want 1 a5a51234", ack_cnt - a0, m_dat_o);
        end
    endtask

    task automatic test_write();
        int a0;
        a0 = ack_cnt;
        drive_req(1'b1, 32'h3000_0008, 32'h1122_3344, 4'b0011);
        exp_q.push_back(32'h0);
        tick();
        total++;
        if (u_sel_o !== 4'b0011 || u_dat_o !== 32'h1122_3344 || u_we_o !== 1'b1) begin
            bad++;
            $display("FAIL write_req sel=%b dat=%h we=%b want 0011 11223344 1", u_sel_o, u_dat_o, u_we_o);
        end
        u_dat_i = 32'hFFFF_0000;
        repeat (3) tick();
        total++;
        if (m_ack_o !== 1'b0 || u_stb_o !== 1'b1) begin
            bad++;
            $display("FAIL write_wait ack=%b stb=%b want 0 1", m_ack_o, u_stb_o);
        end
        u_ack_i = 1'b1;
        tick();
        u_ack_i = 1'b0; drop_req();
        repeat (2) tick();
        total++;
        if (ack_cnt - a0 !== 1 || m_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL write_single_ack acks=%0d dat=%h want 1 0", ack_cnt - a0, m_dat_o);
        end
    endtask

    task automatic test_timeout();
        int n, a0;
        a0 = ack_cnt;
        drive_req(1'b0, 32'h3000_0100, 32'h0, 4'hF);
`ifdef MPRJ_WB_TIMEOUT_EN
        exp_q.push_back(32'hFFFF_FFFF);
        tick();
        wait_ack(3 * TO, n);
        drop_req();
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL timeout_latency edges=%0d want %0d", n, TO);
        end
        total++;
        if (timeout_flag !== 1'b1 || timeout_adr !== 32'h3000_0100) begin
            bad++;
            $display("FAIL timeout_status flag=%b adr=%h want 1 30000100", timeout_flag, timeout_adr);
        end
        tick();
        to_clr = 1'b1;
        tick();
        to_clr = 1'b0;
        total++;
        if (timeout_flag !== 1'b0 || timeout_adr !== 32'h3000_0100) begin
            bad++;
            $display("FAIL timeout_clear flag=%b adr=%h want 0 30000100", timeout_flag, timeout_adr);
        end
        to_clr = 1'b1;
        drive_req(1'b0, 32'h3000_0200, 32'h0, 4'hF);
        exp_q.push_back(32'hFFFF_FFFF);
        tick();
        wait_ack(3 * TO, n);
        drop_req();
        total++;
        if (timeout_flag !== 1'b1 || timeout_adr !== 32'h3000_0200) begin
            bad++;
            $display("FAIL timeout_set_wins flag=%b adr=%h want 1 30000200", timeout_flag, timeout_adr);
        end
        to_clr = 1'b0;
        tick();
`else
        tick();
        repeat (3 * TO) tick();
        total++;
        if (ack_cnt != a0 || u_stb_o !== 1'b1) begin
            bad++;
            $display("FAIL no_timeout_wait acks=%0d stb=%b want 0 1", ack_cnt - a0, u_stb_o);
        end
        drop_req();
        tick();
        total++;
        if (u_cyc_o !== 1'b0 || timeout_flag !== 1'b0 || timeout_adr !== 32'h0) begin
            bad++;
            $display("FAIL no_timeout_status cyc=%b flag=%b adr=%h want 0 0 0", u_cyc_o, timeout_flag, timeout_adr);
        end
`endif
    endtask

    task automatic test_iena_mask();
        int n, a0;
        a0 = ack_cnt;
        m_wb_iena = 1'b0;
        drive_req(1'b0, 32'h3000_0300, 32'h0, 4'hF);
        u_ack_i = 1'b1; u_dat_i = 32'hDEAD_BEEF;
`ifdef MPRJ_WB_TIMEOUT_EN
        exp_q.push_back(32'hFFFF_FFFF);
        tick();
        wait_ack(3 * TO, n);
        drop_req();
        total++;
        if (n !== TO) begin
            bad++;
            $display("FAIL iena_masked_timeout edges=%0d want %0d", n, TO);
        end
        tick();
`else
        tick();
        repeat (TO + 4) tick();
        total++;
        if (ack_cnt != a0 || u_stb_o !== 1'b1) begin
            bad++;
            $display("FAIL iena_masked acks=%0d stb=%b want 0 1", ack_cnt - a0, u_stb_o);
        end
        drop_req();
        tick();
`endif
        u_ack_i = 1'b0;
        m_wb_iena = 1'b1;
        a0 = ack_cnt;
        drive_req(1'b0, 32'h3000_0304, 32'h0, 4'hF);
        exp_q.push_back(32'h0BAD_F00D);
        tick();
        u_ack_i = 1'b1; u_dat_i = 32'h0BAD_F00D;
        tick();
        u_ack_i = 1'b0; drop_req();
        tick();
        total++;
        if (ack_cnt - a0 !== 1) begin
            bad++;
            $display("FAIL iena_reenabled acks=%0d want 1", ack_cnt - a0);
        end
    endtask

    task automatic test_abort_reset();
        int a0;
        a0 = ack_cnt;
        drive_req(1'b0, 32'h3000_0400, 32'h0, 4'hF);
        repeat (3) tick();
        drop_req();
        tick();
        total++;
        if (u_cyc_o !== 1'b0 || u_stb_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_drop cyc=%b stb=%b want 0 0", u_cyc_o, u_stb_o);
        end
        repeat (3) tick();
        total++;
        if (ack_cnt != a0) begin
            bad++;
            $display("FAIL abort_no_ack acks=%0d want 0", ack_cnt - a0);
        end
        drive_req(1'b0, 32'h3000_0500, 32'h0, 4'hF);
        repeat (2) tick();
        core_rstn = 1'b0;
        tick();
        drop_req();
        total++;
        if ({m_ack_o, m_dat_o, u_cyc_o, u_stb_o, u_adr_o, timeout_flag, timeout_adr} !== '0) begin
            bad++;
            $display("FAIL reset_mid_req cyc=%b dat=%h adr=%h flag=%b tadr=%h want all 0",
                     u_cyc_o, m_dat_o, u_adr_o, timeout_flag, timeout_adr);
        end
        core_rstn = 1'b1;
        repeat (2) tick();
        total++;
        if (ack_cnt != a0) begin
            bad++;
            $display("FAIL reset_no_ack acks=%0d want 0", ack_cnt - a0);
        end
    endtask

    task automatic test_back_to_back();
        int a0;
        a0 = ack_cnt;
        drive_req(1'b0, 32'h3000_0600, 32'h0, 4'hF);
        exp_q.push_back(32'h1111_AAAA);
        exp_q.push_back(32'h2222_BBBB);
        tick();
        u_ack_i = 1'b1; u_dat_i = 32'h1111_AAAA;
        tick();
        u_ack_i = 1'b0;
        m_adr_i = 32'h3000_0604;
        tick();
        total++;
        if (u_stb_o !== 1'b0 || u_adr_o !== 32'h3000_0600) begin
            bad++;
            $display("FAIL b2b_no_capture_in_resp stb=%b adr=%h want 0 30000600", u_stb_o, u_adr_o);
        end
        tick();
        total++;
        if (u_stb_o !== 1'b1 || u_adr_o !== 32'h3000_0604) begin
            bad++;
            $display("FAIL b2b_second_capture stb=%b adr=%h want 1 30000604", u_stb_o, u_adr_o);
        end
        u_ack_i = 1'b1; u_dat_i = 32'h2222_BBBB;
        tick();
        u_ack_i = 1'b0; drop_req();
        repeat (3) tick();
        total++;
        if (ack_cnt - a0 !== 2) begin
            bad++;
            $display("FAIL b2b_ack_count acks=%0d want 2", ack_cnt - a0);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_iena_mask();
        test_abort_reset();
        test_back_to_back();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim exceeded time limit");
        $fatal(1, "time limit");
    end
endmodule
